// File: rtl/imem_prog_ctrl_if.sv
// Byte-stream receive and instruction-memory bus bundle for the program loader.
// master is the loader's view; slave is the byte source / memory side.
interface imem_prog_ctrl_if;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [31:0] fetch_addr;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_wdata;

  modport master (
    input  rx_valid, rx_data, fetch_addr,
    output rx_ready, mem_addr, mem_we, mem_wdata
  );

  modport slave (
    output rx_valid, rx_data, fetch_addr,
    input  rx_ready, mem_addr, mem_we, mem_wdata
  );
endinterface

// File: rtl/imem_prog_ctrl.sv
// Instruction memory programmer: assembles little-endian bytes into words,
// writes them sequentially from address 0, stalls the core while loading.
module imem_prog_ctrl #(
  parameter int DEPTH = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_start,
  input  logic [10:0]           load_len,
  imem_prog_ctrl_if.master      bus,
  output logic                  cpu_stall,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [31:0]           checksum
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  localparam logic [11:0] DEPTH_L = 12'(DEPTH);

  state_t      state_q, state_d;
  logic [10:0] word_idx_q;
  logic [10:0] len_q;
  logic [1:0]  byte_cnt_q;
  logic [31:0] word_q;
  logic [31:0] checksum_q;
  logic        err_q;
  logic        len_ok;
  logic        last_word;
  logic        byte_acc;
  logic [31:0] loader_addr;

  assign len_ok      = (load_len != 11'd0) && ({1'b0, load_len} <= DEPTH_L);
  assign last_word   = (word_idx_q == len_q - 11'd1);
  assign byte_acc    = (state_q == LOAD) && bus.rx_valid;
  assign loader_addr = {19'd0, word_idx_q, 2'b00};

  // Control state: everything here returns to a known value on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      word_idx_q <= '0;
      len_q      <= '0;
      byte_cnt_q <= '0;
      checksum_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= (state_q == IDLE) && load_start && !len_ok;
      case (state_q)
        IDLE: begin
          if (load_start && len_ok) begin
            word_idx_q <= '0;
            byte_cnt_q <= '0;
            checksum_q <= '0;
            len_q      <= load_len;
          end
        end
        LOAD: begin
          if (byte_acc) byte_cnt_q <= byte_cnt_q + 2'd1;
        end
        WRITE: begin
          checksum_q <= checksum_q ^ word_q;
          byte_cnt_q <= '0;
          if (!last_word) word_idx_q <= word_idx_q + 11'd1;
        end
        default: ;
      endcase
    end
  end

  // Word assembly datapath; a partial word left by reset is simply overwritten.
  always_ff @(posedge clk) begin
    if (byte_acc) word_q[{byte_cnt_q, 3'b000} +: 8] <= bus.rx_data;
  end

  always_comb begin
    state_d       = state_q;
    bus.rx_ready  = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_wdata = '0;
    bus.mem_addr  = loader_addr;
    done          = 1'b0;
    busy          = 1'b1;
    case (state_q)
      IDLE: begin
        busy         = 1'b0;
        bus.mem_addr = bus.fetch_addr;
        if (load_start && len_ok) state_d = LOAD;
      end
      LOAD: begin
        bus.rx_ready = 1'b1;
        if (bus.rx_valid && byte_cnt_q == 2'd3) state_d = WRITE;
      end
      WRITE: begin
        bus.mem_we    = 1'b1;
        bus.mem_wdata = word_q;
        state_d       = last_word ? DONE : LOAD;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_stall = busy;
  assign err       = err_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_imem_prog_ctrl.sv
// Directed bench for imem_prog_ctrl with a write scoreboard fed by the stimulus.
module tb_imem_prog_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_start;
  logic [10:0] load_len;
  logic        cpu_stall, busy, done, err;
  logic [31:0] checksum;

  imem_prog_ctrl_if bus();

  imem_prog_ctrl #(.DEPTH(1024)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_start (load_start),
    .load_len   (load_len),
    .bus        (bus),
    .cpu_stall  (cpu_stall),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .checksum   (checksum)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          done_cnt = 0;
  logic [31:0] last_addr = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory-side monitor: every write must match the next expected word.
  always @(negedge clk) begin
    wr_t e;
    if (bus.mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", bus.mem_addr, 32'hDEAD_BEEF);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", bus.mem_addr, e.addr);
        check("wr_data", bus.mem_wdata, e.data);
        check("rx_ready_in_write", {31'd0, bus.rx_ready}, 32'd0);
        last_addr = bus.mem_addr;
      end
    end else begin
      check("wdata_zero_idle", bus.mem_wdata, 32'd0);
    end
    if (done === 1'b1) done_cnt++;
  end

  task automatic start(input logic [10:0] len);
    load_start = 1'b1;
    load_len   = len;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic acc = 1'b0;
    int   n   = 0;
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!acc && n < 50) begin
      @(negedge clk);
      acc = bus.rx_ready;
      @(posedge clk); #1;
      n++;
    end
    bus.rx_valid = 1'b0;
    if (!acc) check("byte_accept_timeout", {31'd0, acc}, 32'd1);
  endtask

  task automatic send_word(input int idx, input logic [31:0] w, input int gap, input bit expect_write);
    wr_t e;
    if (expect_write) begin
      e.addr = 32'(idx) << 2;
      e.data = w;
      exp_q.push_back(e);
    end
    for (int k = 0; k < 4; k++) begin
      send_byte(w[8*k +: 8]);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    check("done_seen", {31'd0, done}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check("done_one_cycle", {31'd0, done}, 32'd0);
    check("busy_after_done", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int          d0;
    logic [31:0] w, model_cs;

    rst_n          = 1'b0;
    load_start     = 1'b0;
    load_len       = '0;
    bus.rx_valid   = 1'b0;
    bus.rx_data    = '0;
    bus.fetch_addr = 32'h0000_0040;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("rst_we", {31'd0, bus.mem_we}, 32'd0);
    check("rst_done_err", {30'd0, done, err}, 32'd0);
    check("rst_checksum", checksum, 32'd0);
    check("rst_addr_pass", bus.mem_addr, 32'h40);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Single word load.
    start(11'd1);
    @(negedge clk);
    check("t1_busy", {30'd0, busy, cpu_stall}, 32'd3);
    @(posedge clk); #1;
    d0 = done_cnt;
    send_word(0, 32'h1234_5678, 0, 1'b1);
    wait_done(10);
    check("t1_checksum", checksum, 32'h1234_5678);
    check("t1_done_cnt", 32'(done_cnt - d0), 32'd1);

    // Two words with gaps in the byte stream.
    start(11'd2);
    send_word(0, 32'h0000_0013, 2, 1'b1);
    send_word(1, 32'hFFFF_FFFF, 1, 1'b1);
    wait_done(10);
    check("t2_checksum", checksum, 32'hFFFF_FFEC);

    // Illegal lengths: error pulse only, loader stays idle.
    start(11'd0);
    @(negedge clk);
    check("t3_err_len0", {31'd0, err}, 32'd1);
    check("t3_busy_len0", {31'd0, busy}, 32'd0);
    check("t3_addr_len0", bus.mem_addr, 32'h40);
    @(posedge clk); #1;
    @(negedge clk);
    check("t3_err_pulse", {31'd0, err}, 32'd0);
    @(posedge clk); #1;
    start(11'd1025);
    @(negedge clk);
    check("t3_err_len1025", {31'd0, err}, 32'd1);
    check("t3_busy_len1025", {31'd0, busy}, 32'd0);
    check("t3_we_len1025", {31'd0, bus.mem_we}, 32'd0);
    check("t3_cs_held", checksum, 32'hFFFF_FFEC);
    @(posedge clk); #1;

    // Restart attempt mid-load is ignored.
    start(11'd2);
    exp_q.push_back('{addr: 32'h0, data: 32'hCAFE_BABE});
    send_byte(8'hBE);
    send_byte(8'hBA);
    start(11'd5);
    @(negedge clk);
    check("t4_no_err", {31'd0, err}, 32'd0);
    check("t4_still_busy", {31'd0, busy}, 32'd1);
    @(posedge clk); #1;
    send_byte(8'hFE);
    send_byte(8'hCA);
    send_word(1, 32'h0BAD_F00D, 0, 1'b1);
    wait_done(10);
    check("t4_checksum", checksum, 32'hCAFE_BABE ^ 32'h0BAD_F00D);

    // Reset in the middle of word 3 of an 8-word load.
    start(11'd8);
    for (int i = 0; i < 3; i++) send_word(i, 32'h1111_1111 * (i + 1), 0, 1'b1);
    send_byte(8'h44);
    send_byte(8'h55);
    d0 = done_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("t5_stall", {31'd0, cpu_stall}, 32'd0);
    check("t5_busy", {31'd0, busy}, 32'd0);
    check("t5_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
    check("t5_checksum", checksum, 32'd0);
    check("t5_addr_pass", bus.mem_addr, 32'h40);
    bus.rx_valid = 1'b1;
    bus.rx_data  = 8'h66;
    repeat (12) begin @(posedge clk); #1; end
    bus.rx_valid = 1'b0;
    check("t5_no_done", 32'(done_cnt - d0), 32'd0);
    check("t5_queue_empty", 32'(exp_q.size()), 32'd0);

    // Full-depth load.
    model_cs = '0;
    start(11'd1024);
    d0 = done_cnt;
    for (int i = 0; i < 1024; i++) begin
      w = 32'(i) * 32'h9E37_79B1 + 32'h13;
      model_cs ^= w;
      send_word(i, w, 0, 1'b1);
    end
    wait_done(10);
    check("t6_last_addr", last_addr, 32'h0000_0FFC);
    check("t6_done_once", 32'(done_cnt - d0), 32'd1);
    check("t6_checksum", checksum, model_cs);
    check("t6_queue_empty", 32'(exp_q.size()), 32'd0);
    @(negedge clk);
    check("t6_idle_busy", {30'd0, busy, cpu_stall}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_prog_ctrl.md
IMEM_PROG_CTRL -- requirements
Module: imem_prog_ctrl

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning instruction memory size in 32-bit words.
REQ-002 SHALL have ports as follows (one clock; reset is synchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- load_start  input  1  single-cycle request to begin programming
- load_len  input  11  number of words to load, sampled with load_start
- rx_valid  input  1  byte available
- rx_data  input  8  byte stream, little-endian words
- rx_ready  output  1  byte accepted when rx_valid&rx_ready
- fetch_addr  input  32  core PC byte address
- mem_addr  output  32  byte address to instruction memory
- mem_we  output  1  instruction memory write enable
- mem_wdata  output  32  write word
- cpu_stall  output  1  holds core while programming
- busy  output  1  programming in progress
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle bad-request pulse
- checksum  output  32  XOR of all words written in last load

Function
REQ-003 SHALL implement FSM states IDLE, LOAD, WRITE, DONE.
REQ-004 IDLE: load_start with 1<=load_len<=DEPTH -> LOAD; word index=0, byte count=0, checksum=0, len latched.
REQ-005 IDLE: load_start with load_len==0 or >DEPTH -> err=1 for one cycle, remain IDLE.
REQ-006 load_start outside IDLE SHALL be ignored (no err, no restart).
REQ-007 rx_ready SHALL be 1 only in LOAD; 0 in IDLE, WRITE, DONE.
REQ-008 LOAD: each accepted byte k (0..3) SHALL go to word bits [8k+7:8k]; byte 0 first.
REQ-009 Acceptance of 4th byte SHALL transition to WRITE next cycle; rx_valid without rx_ready SHALL not advance.
REQ-010 WRITE (exactly one cycle): mem_we=1, mem_addr={word_idx,2'b00} zero-extended, mem_wdata=assembled word, checksum^=word.
REQ-011 WRITE exit: word_idx==len-1 -> DONE, else word_idx+1 and LOAD with byte count 0.
REQ-012 DONE (one cycle): done=1; next state IDLE.
REQ-013 busy and cpu_stall SHALL be 1 in LOAD, WRITE, DONE; 0 in IDLE.
REQ-014 IDLE: mem_addr=fetch_addr (combinational passthrough), mem_we=0; otherwise mem_addr driven by loader.
REQ-015 mem_wdata SHALL be 0 whenever mem_we=0.
REQ-016 checksum SHALL hold final value after DONE until next valid load_start.
REQ-017 Word index SHALL never exceed DEPTH-1; no address wrap.

Reset
REQ-018 rst_n=0 at clk edge SHALL force IDLE; rx_ready, mem_we, busy, cpu_stall, done, err=0; checksum=0; counters=0.
REQ-019 Reset mid-load SHALL discard partial word; already-written words not rolled back; no done pulse.

Verification
- Reset, load_start len=1, bytes 78,56,34,12 -> one WRITE: mem_addr=0, mem_wdata=0x12345678, done next cycle, checksum=0x12345678.
- len=2, words 0x00000013 then 0xFFFFFFFF, rx_valid toggled with gaps -> writes at addr 0 and 4, checksum=0xFFFFFFEC, rx_ready=0 during WRITE.
- load_start len=0 and len=1025 -> err pulse each, busy stays 0, mem_addr tracks fetch_addr=0x40.
- load_start pulsed again during LOAD -> ignored, byte count and word index unchanged.
- rst_n low after 2 bytes of word 3 of len=8 -> next cycle IDLE, cpu_stall=0, no further writes, no done.
- len=1024 full stream -> last write mem_addr=0xFFC, done once, busy 0 after.
